// File: rtl/relu_requant_stream_pkg.sv
// Shared widths, FSM encoding and helpers for the layer-1 ReLU/requant output stage.
package relu_requant_stream_pkg;

  localparam int RELU_NODES            = 4;
  localparam int LAYER_1_OUT_BIT_WIDTH = 16;
  localparam int LAYER_2_BIT_WIDTH     = 8;
  localparam int RELU_SHIFT_WIDTH      = 5;

  typedef enum logic {
    RELU_ST_IDLE   = 1'b0,
    RELU_ST_STREAM = 1'b1
  } relu_state_t;

  function automatic int idx_width(input int nodes);
    return (nodes > 1) ? $clog2(nodes) : 1;
  endfunction

endpackage

// File: rtl/relu_requant_stream_if.sv
// Capture-side (sum*) and stream-side (act*) handshake bundle of relu_requant_stream.
interface relu_requant_stream_if
  import relu_requant_stream_pkg::*;
#(
  parameter int NODES   = RELU_NODES,
  parameter int IN_W    = LAYER_1_OUT_BIT_WIDTH,
  parameter int OUT_W   = LAYER_2_BIT_WIDTH,
  parameter int SHIFT_W = RELU_SHIFT_WIDTH
);
  localparam int IDX_W = idx_width(NODES);

  logic [NODES*IN_W-1:0] sumIn;
  logic                  sumValid;
  logic                  sumReady;
  logic [SHIFT_W-1:0]    shiftAmt;
  logic [OUT_W-1:0]      actOut;
  logic [IDX_W-1:0]      actIndex;
  logic                  actValid;
  logic                  actReady;
  logic                  actLast;
  logic                  satFlag;

  modport master (
    output sumIn, sumValid, shiftAmt, actReady,
    input  sumReady, actOut, actIndex, actValid, actLast, satFlag
  );

  modport slave (
    input  sumIn, sumValid, shiftAmt, actReady,
    output sumReady, actOut, actIndex, actValid, actLast, satFlag
  );

endinterface

// File: rtl/relu_requant_stream_lane.sv
// Combinational per-lane ReLU, right-shift requantisation and saturation.
// Build option RELU_ROUND_EN selects round-half-up instead of truncation.
module relu_requant_lane
  import relu_requant_stream_pkg::*;
#(
  parameter int IN_W    = LAYER_1_OUT_BIT_WIDTH,
  parameter int OUT_W   = LAYER_2_BIT_WIDTH,
  parameter int SHIFT_W = RELU_SHIFT_WIDTH
)(
  input  logic signed [IN_W-1:0]    x,
  input  logic        [SHIFT_W-1:0] s,
  output logic        [OUT_W-1:0]   act,
  output logic                      sat
);
  localparam int EXT_W = IN_W + 1;

  // One spare bit keeps the rounding addend from wrapping.
  function automatic logic [EXT_W-1:0] requant(input logic [EXT_W-1:0] mag,
                                               input logic [SHIFT_W-1:0] sh);
    logic [EXT_W-1:0] v;
    if (32'(sh) >= IN_W) begin
      v = '0;
    end else begin
`ifdef RELU_ROUND_EN
      if (sh != '0) v = (mag + (EXT_W'(1) << (sh - 1'b1))) >> sh;
      else          v = mag;
`else
      v = mag >> sh;
`endif
    end
    return v;
  endfunction

  function automatic logic [OUT_W:0] saturate(input logic [EXT_W-1:0] v);
    if (|v[EXT_W-1:OUT_W]) return {1'b1, {OUT_W{1'b1}}};
    else                   return {1'b0, v[OUT_W-1:0]};
  endfunction

  always_comb begin
    act = '0;
    sat = 1'b0;
    if (!x[IN_W-1]) {sat, act} = saturate(requant({1'b0, x}, s));
  end

endmodule

// File: rtl/relu_requant_stream.sv
// Layer-1 output stage: captures a frame of accumulator sums and streams requantised
// activations one node per cycle. Rounding mode is chosen by RELU_ROUND_EN (see lane).
module relu_requant_stream
  import relu_requant_stream_pkg::*;
#(
  parameter int NODES   = RELU_NODES,
  parameter int IN_W    = LAYER_1_OUT_BIT_WIDTH,
  parameter int OUT_W   = LAYER_2_BIT_WIDTH,
  parameter int SHIFT_W = RELU_SHIFT_WIDTH
)(
  input logic                   clk,
  input logic                   clr,
  relu_requant_stream_if.slave  bus
);
  localparam int               IDX_W    = idx_width(NODES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);

  relu_state_t state, state_n;

  logic signed [IN_W-1:0]    lanes_p0 [NODES];
  logic        [SHIFT_W-1:0] shift_p0;

  logic [OUT_W-1:0] act_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             vld_p1;
  logic             last_p1;
  logic             sat_p1;

  logic [IDX_W-1:0]       idx_n;
  logic                   capture;
  logic                   load;
  logic signed [IN_W-1:0] sel_x;
  logic [SHIFT_W-1:0]     sel_s;
  logic [OUT_W-1:0]       lane_act;
  logic                   lane_sat;

  assign bus.sumReady = (state == RELU_ST_IDLE) && !clr;

  always_comb begin
    state_n = state;
    idx_n   = idx_p1;
    capture = 1'b0;
    load    = 1'b0;
    case (state)
      RELU_ST_IDLE: begin
        if (bus.sumValid) begin
          capture = 1'b1;
          load    = 1'b1;
          idx_n   = '0;
          state_n = RELU_ST_STREAM;
        end
      end
      RELU_ST_STREAM: begin
        if (bus.actReady) begin
          if (idx_p1 == LAST_IDX) begin
            idx_n   = '0;
            state_n = RELU_ST_IDLE;
          end else begin
            idx_n = idx_p1 + 1'b1;
            load  = 1'b1;
          end
        end
      end
      default: state_n = RELU_ST_IDLE;
    endcase
  end

  // Lane 0 comes straight from the input bus on capture so it can be shown next cycle.
  always_comb begin
    sel_x = lanes_p0[idx_n];
    sel_s = shift_p0;
    if (capture) begin
      sel_x = $signed(bus.sumIn[IN_W-1:0]);
      sel_s = bus.shiftAmt;
    end
  end

  relu_requant_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_lane (
    .x   (sel_x),
    .s   (sel_s),
    .act (lane_act),
    .sat (lane_sat)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= RELU_ST_IDLE;
    else     state <= state_n;
  end

  // Stage p0: frame capture buffer
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int m = 0; m < NODES; m++) lanes_p0[m] <= $signed(bus.sumIn[m*IN_W +: IN_W]);
      shift_p0 <= bus.shiftAmt;
    end
  end

  // Stage p1: registered activation outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      act_p1  <= '0;
      idx_p1  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      sat_p1  <= 1'b0;
    end else if (load) begin
      act_p1  <= lane_act;
      idx_p1  <= idx_n;
      vld_p1  <= 1'b1;
      last_p1 <= (idx_n == LAST_IDX);
      sat_p1  <= lane_sat | (sat_p1 & !capture);
    end else if (state == RELU_ST_STREAM && bus.actReady) begin
      idx_p1  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign bus.actOut   = act_p1;
  assign bus.actIndex = idx_p1;
  assign bus.actValid = vld_p1;
  assign bus.actLast  = last_p1;
  assign bus.satFlag  = sat_p1;

endmodule
